// File: rtl/pet_care_scheduler.sv
// Pet stat sequencer: captures care-button rising edges, generates the periodic decay tick,
// and arbitrates decay and actions round-robin through one saturating update path.
module pet_care_scheduler #(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
    parameter logic [7:0]  COOLDOWN   = 8'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] action_req,
    output logic [5:0] action_ack,
    output logic [3:0] hunger,
    output logic [3:0] happiness,
    output logic [3:0] health,
    output logic [3:0] hygiene,
    output logic [3:0] energy,
    output logic [3:0] social,
    output logic       tick,
    output logic       busy,
    output logic       tick_overrun
);

    localparam int HUN = 0;
    localparam int HAP = 1;
    localparam int HEA = 2;
    localparam int HYG = 3;
    localparam int ENE = 4;
    localparam int SOC = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_COOL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cool_q, cool_d;
    logic [2:0]  rr_q, rr_d;
    logic [5:0]  pending_q, pending_d;
    logic [5:0]  req_q;
    logic [23:0] cnt_q, cnt_d;
    logic        tick_pending_q, tick_pending_d;
    logic        overrun_q, overrun_d;
    logic [5:0]  ack_q, ack_d;
    logic        tick_q, tick_d;
    logic [3:0]  stat_q [6];
    logic [3:0]  stat_d [6];

    logic        grant_vld;
    logic [2:0]  grant_idx;
    logic [3:0]  cand;
    logic [5:0]  grant_clr;
    logic        tick_clr;
    logic        wrap;

    function automatic logic [3:0] sat_add(input logic [3:0] v, input logic [3:0] inc);
        logic [4:0] s;
        s = {1'b0, v} + {1'b0, inc};
        return s[4] ? 4'd15 : s[3:0];
    endfunction

    function automatic logic [3:0] sat_sub(input logic [3:0] v, input logic [3:0] dec);
        return (v < dec) ? 4'd0 : (v - dec);
    endfunction

    // Round-robin search starts just after the last granted index.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        cand      = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            cand = {1'b0, rr_q} + 4'(k);
            if (cand >= 4'd6) begin
                cand = cand - 4'd6;
            end
            if (!grant_vld && pending_q[cand[2:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[2:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cool_d    = cool_q;
        rr_d      = rr_q;
        ack_d     = 6'd0;
        tick_d    = 1'b0;
        grant_clr = 6'd0;
        tick_clr  = 1'b0;
        for (int s = 0; s < 6; s++) begin
            stat_d[s] = stat_q[s];
        end

        case (state_q)
            S_IDLE: begin
                if (tick_pending_q) begin
                    stat_d[HUN] = sat_add(stat_q[HUN], 4'd1);
                    stat_d[HAP] = sat_sub(stat_q[HAP], 4'd1);
                    stat_d[HYG] = sat_sub(stat_q[HYG], 4'd1);
                    stat_d[ENE] = sat_sub(stat_q[ENE], 4'd1);
                    stat_d[SOC] = sat_sub(stat_q[SOC], 4'd1);
                    if (stat_q[HUN] == 4'd15 || stat_q[HYG] == 4'd0) begin
                        stat_d[HEA] = sat_sub(stat_q[HEA], 4'd1);
                    end
                    tick_d   = 1'b1;
                    tick_clr = 1'b1;
                end else if (grant_vld) begin
                    ack_d     = 6'd1 << grant_idx;
                    grant_clr = 6'd1 << grant_idx;
                    rr_d      = grant_idx;
                    case (grant_idx)
                        3'd0: begin
                            stat_d[HUN] = sat_sub(stat_q[HUN], 4'd4);
                            stat_d[HEA] = sat_add(stat_q[HEA], 4'd1);
                        end
                        3'd1: begin
                            stat_d[HAP] = sat_add(stat_q[HAP], 4'd3);
                            stat_d[ENE] = sat_sub(stat_q[ENE], 4'd2);
                            stat_d[HYG] = sat_sub(stat_q[HYG], 4'd1);
                        end
                        3'd2: stat_d[HYG] = 4'd15;
                        3'd3: stat_d[ENE] = sat_add(stat_q[ENE], 4'd5);
                        3'd4: begin
                            stat_d[SOC] = sat_add(stat_q[SOC], 4'd3);
                            stat_d[HAP] = sat_add(stat_q[HAP], 4'd1);
                        end
                        3'd5: stat_d[HEA] = sat_add(stat_q[HEA], 4'd4);
                        default: ;
                    endcase
                    if (COOLDOWN != 8'd0) begin
                        state_d = S_COOL;
                        cool_d  = COOLDOWN;
                    end
                end
            end
            S_COOL: begin
                cool_d = cool_q - 8'd1;
                if (cool_q <= 8'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A wrap while a tick is still waiting keeps it pending and flags the loss.
    always_comb begin
        wrap           = (cnt_q == TICK_COUNT - 24'd1);
        cnt_d          = wrap ? 24'd0 : cnt_q + 24'd1;
        tick_pending_d = wrap | (tick_pending_q & ~tick_clr);
        overrun_d      = overrun_q | (wrap & tick_pending_q);
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_pending
            assign pending_d[gi] = (pending_q[gi] & ~grant_clr[gi]) | (action_req[gi] & ~req_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cool_q         <= 8'd0;
            rr_q           <= 3'd5;
            pending_q      <= 6'd0;
            req_q          <= 6'd0;
            cnt_q          <= 24'd0;
            tick_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
            ack_q          <= 6'd0;
            tick_q         <= 1'b0;
            for (int s = 0; s < 6; s++) begin
                stat_q[s] <= (s == HUN) ? 4'd0 : 4'd15;
            end
        end else begin
            state_q        <= state_d;
            cool_q         <= cool_d;
            rr_q           <= rr_d;
            pending_q      <= pending_d;
            req_q          <= action_req;
            cnt_q          <= cnt_d;
            tick_pending_q <= tick_pending_d;
            overrun_q      <= overrun_d;
            ack_q          <= ack_d;
            tick_q         <= tick_d;
            for (int s = 0; s < 6; s++) begin
                stat_q[s] <= stat_d[s];
            end
        end
    end

    assign action_ack   = ack_q;
    assign tick         = tick_q;
    assign busy         = (state_q == S_COOL);
    assign tick_overrun = overrun_q;
    assign hunger       = stat_q[HUN];
    assign happiness    = stat_q[HAP];
    assign health       = stat_q[HEA];
    assign hygiene      = stat_q[HYG];
    assign energy       = stat_q[ENE];
    assign social       = stat_q[SOC];

endmodule

// File: tb/tb_pet_care_scheduler.sv
// Bench for pet_care_scheduler: four parameterisations share one stimulus stream; each is
// compared every cycle against a behavioural model, plus hand-computed spot checks.
module tb_pet_care_scheduler;

    localparam int A = 0;  // TICK_COUNT 4,    COOLDOWN 4
    localparam int B = 1;  // TICK_COUNT 1000, COOLDOWN 4
    localparam int C = 2;  // TICK_COUNT 2,    COOLDOWN 8
    localparam int D = 3;  // TICK_COUNT 1000, COOLDOWN 0

    function automatic int tc_of(int i);
        case (i)
            0: return 4;
            2: return 2;
            default: return 1000;
        endcase
    endfunction

    function automatic int cd_of(int i);
        case (i)
            2: return 8;
            3: return 0;
            default: return 4;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] action_req;
    logic [5:0] ack_w  [4];
    logic [3:0] st_w   [4][6];
    logic       tick_w [4];
    logic       busy_w [4];
    logic       ovr_w  [4];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            pet_care_scheduler #(
                .TICK_COUNT(24'(tc_of(gi))),
                .COOLDOWN  (8'(cd_of(gi)))
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .action_req  (action_req),
                .action_ack  (ack_w[gi]),
                .hunger      (st_w[gi][0]),
                .happiness   (st_w[gi][1]),
                .health      (st_w[gi][2]),
                .hygiene     (st_w[gi][3]),
                .energy      (st_w[gi][4]),
                .social      (st_w[gi][5]),
                .tick        (tick_w[gi]),
                .busy        (busy_w[gi]),
                .tick_overrun(ovr_w[gi])
            );
        end
    endgenerate

    // Stat order: hunger, happiness, health, hygiene, energy, social.
    typedef struct packed {
        logic [5:0][3:0] st;
        logic [5:0]      pend;
        logic [5:0]      prev;
        logic [5:0]      ack;
        logic [2:0]      last;
        logic [23:0]     cnt;
        logic            tpend;
        logic            ovr;
        logic            tick;
        logic [7:0]      wait_left;
    } mdl_t;

    // Per-action stat deltas; clean as +15 saturates hygiene to full.
    localparam int DLT [6][6] = '{
        '{-4, 0, 1,  0,  0, 0},
        '{ 0, 3, 0, -1, -2, 0},
        '{ 0, 0, 0, 15,  0, 0},
        '{ 0, 0, 0,  0,  5, 0},
        '{ 0, 1, 0,  0,  0, 3},
        '{ 0, 0, 4,  0,  0, 0}
    };

    function automatic logic [3:0] clamp(int v);
        if (v < 0) return 4'd0;
        if (v > 15) return 4'd15;
        return 4'(v);
    endfunction

    function automatic mdl_t mreset();
        mdl_t r;
        r = '0;
        for (int s = 1; s < 6; s++) r.st[s] = 4'd15;
        r.last = 3'd5;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [5:0] req, int tc, int cd);
        mdl_t n;
        int   g;
        int   v;
        int   idx;
        bit   tclr;
        n      = m;
        n.ack  = '0;
        n.tick = 1'b0;
        tclr   = 1'b0;
        g      = -1;
        if (m.wait_left != 8'd0) begin
            n.wait_left = m.wait_left - 8'd1;
        end else if (m.tpend) begin
            for (int s = 0; s < 6; s++) begin
                v = int'(m.st[s]);
                if (s == 0) v = v + 1;
                else if (s == 2) v = v - ((m.st[0] == 4'd15 || m.st[3] == 4'd0) ? 1 : 0);
                else v = v - 1;
                n.st[s] = clamp(v);
            end
            n.tick = 1'b1;
            tclr   = 1'b1;
        end else if (m.pend != 6'd0) begin
            for (int k = 1; k <= 6; k++) begin
                idx = (int'(m.last) + k) % 6;
                if (g < 0 && m.pend[idx]) g = idx;
            end
            for (int s = 0; s < 6; s++) n.st[s] = clamp(int'(m.st[s]) + DLT[g][s]);
            n.ack[g]    = 1'b1;
            n.pend[g]   = 1'b0;
            n.last      = 3'(g);
            n.wait_left = 8'(cd);
        end
        if (int'(m.cnt) == tc - 1) begin
            n.cnt = '0;
            if (m.tpend) n.ovr = 1'b1;
            n.tpend = 1'b1;
        end else begin
            n.cnt = m.cnt + 24'd1;
            if (tclr) n.tpend = 1'b0;
        end
        n.pend = n.pend | (req & ~m.prev);
        n.prev = req;
        return n;
    endfunction

    mdl_t mdl [4];
    int   ackcnt [4] = '{0, 0, 0, 0};
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            mdl[i]    <= reset ? mreset() : mstep(mdl[i], action_req, tc_of(i), cd_of(i));
            ackcnt[i] <= ackcnt[i] + $countones(ack_w[i]);
        end
    end

    task automatic compare_all();
        logic [32:0] got;
        logic [32:0] want;
        for (int i = 0; i < 4; i++) begin
            got  = {ack_w[i], tick_w[i], busy_w[i], ovr_w[i],
                    st_w[i][0], st_w[i][1], st_w[i][2], st_w[i][3], st_w[i][4], st_w[i][5]};
            want = {mdl[i].ack, mdl[i].tick, mdl[i].wait_left != 8'd0, mdl[i].ovr,
                    mdl[i].st[0], mdl[i].st[1], mdl[i].st[2], mdl[i].st[3], mdl[i].st[4], mdl[i].st[5]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cycle_model dut%0d t=%0t got %h want %h (ack,tick,busy,ovr,stats)",
                         i, $time, got, want);
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int snap;
        reset      = 1'b1;
        action_req = 6'd0;
        fork
            begin
                repeat (2) @(negedge clk);
                while (!done) begin
                    compare_all();
                    @(negedge clk);
                end
            end
            begin
                // Reset state and decay ticks on A
                step(3);
                chk("rst_hunger",    int'(st_w[A][0]), 0);
                chk("rst_happiness", int'(st_w[A][1]), 15);
                chk("rst_ack",       int'(ack_w[A]),   0);
                chk("rst_tick",      int'(tick_w[A]),  0);
                chk("rst_overrun",   int'(ovr_w[A]),   0);
                chk("rst_busy",      int'(busy_w[A]),  0);
                reset = 1'b0;
                step(5);
                chk("tick1_pulse",     int'(tick_w[A]),  1);
                chk("tick1_hunger",    int'(st_w[A][0]), 1);
                chk("tick1_happiness", int'(st_w[A][1]), 14);
                chk("tick1_health",    int'(st_w[A][2]), 15);
                step(56);
                chk("tick15_hunger",  int'(st_w[A][0]), 15);
                chk("tick15_hygiene", int'(st_w[A][3]), 0);
                chk("tick15_health",  int'(st_w[A][2]), 15);
                step(3);
                chk("gap_tick",   int'(tick_w[A]),  0);
                chk("gap_health", int'(st_w[A][2]), 15);
                step(1);
                chk("tick16_pulse",  int'(tick_w[A]),  1);
                chk("tick16_health", int'(st_w[A][2]), 14);

                // Feed with hunger=10 on A, then hold the button
                reset = 1'b1;
                step(2);
                reset = 1'b0;
                step(41);
                chk("pre_feed_hunger", int'(st_w[A][0]), 10);
                snap = ackcnt[A];
                action_req = 6'b000001;
                step(2);
                chk("feed_ack",    int'(ack_w[A]),   1);
                chk("feed_hunger", int'(st_w[A][0]), 6);
                chk("feed_health", int'(st_w[A][2]), 15);
                step(1);
                chk("feed_ack_one_cycle", int'(ack_w[A]), 0);
                step(48);
                chk("feed_hold_single_ack", ackcnt[A] - snap, 1);
                action_req = 6'd0;

                // Three simultaneous requests; B has COOLDOWN 4, D has COOLDOWN 0
                reset = 1'b1;
                step(2);
                reset = 1'b0;
                step(2);
                action_req = 6'b100011;
                step(2);
                chk("multi_b_ack0", int'(ack_w[B]), 6'b000001);
                chk("multi_d_ack0", int'(ack_w[D]), 6'b000001);
                step(1);
                chk("multi_b_gap_ack", int'(ack_w[B]), 0);
                chk("multi_d_ack1",    int'(ack_w[D]), 6'b000010);
                step(1);
                chk("multi_b_busy",   int'(busy_w[B]), 1);
                chk("multi_d_ack5",   int'(ack_w[D]),  6'b100000);
                chk("multi_d_nobusy", int'(busy_w[D]), 0);
                step(3);
                chk("multi_b_ack1", int'(ack_w[B]), 6'b000010);
                step(3);
                chk("multi_b_busy_last", int'(busy_w[B]), 1);
                step(1);
                chk("multi_b_idle", int'(busy_w[B]), 0);
                step(1);
                chk("multi_b_ack5",    int'(ack_w[B]),   6'b100000);
                chk("multi_b_energy",  int'(st_w[B][4]), 13);
                chk("multi_b_hygiene", int'(st_w[B][3]), 14);
                step(1);
                action_req = 6'd0;

                // Round-robin: after bit1, pending {0,2} grants bit2 first
                step(5);
                action_req = 6'b000010;
                step(2);
                chk("rr_b_ack1", int'(ack_w[B]), 6'b000010);
                action_req = 6'b000111;
                step(5);
                chk("rr_b_ack2", int'(ack_w[B]), 6'b000100);
                step(5);
                chk("rr_b_ack0", int'(ack_w[B]), 6'b000001);
                action_req = 6'd0;

                // Tick and action together on A; overrun on C
                reset = 1'b1;
                step(2);
                reset = 1'b0;
                step(3);
                action_req = 6'b001000;
                step(2);
                chk("tickfirst_tick", int'(tick_w[A]), 1);
                chk("tickfirst_ack",  int'(ack_w[A]),  0);
                step(1);
                chk("action_next_tick",  int'(tick_w[A]),  0);
                chk("action_next_ack",   int'(ack_w[A]),   6'b001000);
                chk("action_next_energy", int'(st_w[A][4]), 15);
                chk("action_next_hunger", int'(st_w[A][0]), 1);
                step(1);
                chk("c_busy",        int'(busy_w[C]), 1);
                chk("c_overrun_pre", int'(ovr_w[C]),  0);
                step(1);
                chk("c_overrun_set", int'(ovr_w[C]), 1);
                step(22);
                chk("c_overrun_sticky", int'(ovr_w[C]), 1);

                // Reset during COOL with a request still pending on B
                action_req = 6'b001011;
                step(2);
                chk("pre_reset_b_ack", int'(ack_w[B]), 6'b000001);
                step(1);
                chk("pre_reset_b_busy", int'(busy_w[B]), 1);
                reset      = 1'b1;
                action_req = 6'd0;
                step(1);
                chk("midrst_a_hunger",    int'(st_w[A][0]), 0);
                chk("midrst_a_happiness", int'(st_w[A][1]), 15);
                chk("midrst_b_busy",      int'(busy_w[B]),  0);
                chk("midrst_b_ack",       int'(ack_w[B]),   0);
                snap  = ackcnt[B];
                reset = 1'b0;
                step(20);
                chk("postrst_b_no_ack", ackcnt[B] - snap, 0);
                chk("postrst_b_idle",   int'(busy_w[B]),  0);
                done = 1'b1;
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pet_care_scheduler.md
# pet_care_scheduler

Sequencer and arbiter for the pet's shared stat register file. It edge-detects six care-action buttons and queues them as pending requests. It generates the periodic decay tick and serialises decay and actions through one read-modify-write path with round-robin fairness and a post-action cooldown. It sits between the input switches and the status/display logic, and it owns the six 4-bit stat registers.

## Interface
- `TICK_COUNT`, default 24'd10_000_000: clock cycles per decay tick (≥2).
- `COOLDOWN`, default 8'd4: idle cycles enforced after each serviced action (0 allowed).
- `clk`, input, 1: system clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `action_req`, input, 6: button levels. Bit 0 feed, 1 play, 2 clean, 3 sleep, 4 social, 5 heal.
- `action_ack`, output, 6: one-hot, one-cycle pulse when that action is applied.
- `hunger`, `happiness`, `health`, `hygiene`, `energy`, `social`, output, 4 each: stat registers.
- `tick`, output, 1: one-cycle pulse when decay is applied.
- `busy`, output, 1: high whenever the FSM is not IDLE.
- `tick_overrun`, output, 1: sticky flag; a tick was dropped because the previous one was still pending.

## Operation
- Reset values:
  - Stats: hunger 0; happiness, health, hygiene, energy, social 15.
  - `action_ack` 0, `tick` 0, `tick_overrun` 0.
  - pending 0, req_q 0, tick counter 0, tick_pending 0.
  - rr_ptr 5, so the first search starts at bit 0. FSM in IDLE.
- Request capture: pending[i] is set on any edge where `action_req[i]`=1 and req_q[i]=0; req_q <= `action_req`.
  - Held levels never re-request.
  - If a capture and a clear hit the same bit on the same edge, the capture wins (bit stays set).
- Tick generator:
  - Counter runs 0..TICK_COUNT-1 and wraps.
  - When count==TICK_COUNT-1, tick_pending is set.
  - If tick_pending is already set at that point, it stays set and `tick_overrun` is set.
- FSM states: IDLE, COOL.
  - IDLE with tick_pending: apply DECAY, pulse `tick`, clear tick_pending, stay IDLE. Decay has priority over actions.
  - IDLE, no tick_pending, pending≠0:
    - Grant the first set bit searching rr_ptr+1, rr_ptr+2, … modulo 6.
    - Apply that action, pulse its `action_ack` bit, clear its pending bit, rr_ptr <= granted index.
    - Go to COOL with cooldown counter=COOLDOWN; if COOLDOWN==0, stay IDLE.
  - COOL: decrement the counter each cycle; when it reaches 1, go to IDLE. Captures and ticks still accumulate during COOL.
- Arithmetic: all stat updates saturate to 0..15 and compute from pre-update values.
  - feed: hunger −4, health +1.
  - play: happiness +3, energy −2, hygiene −1.
  - clean: hygiene := 15.
  - sleep: energy +5.
  - social: social +3, happiness +1.
  - heal: health +4.
  - DECAY: hunger +1; happiness, hygiene, energy, social each −1. Health −1 only if (pre-decay) hunger==15 or hygiene==0.
- Reset mid-operation returns every register to its reset value on that edge. In-flight pending requests and ticks are discarded.

## Timing
- A request rising at sample edge k has pending set at k. If IDLE and no tick is pending, stats update and `action_ack` goes high at edge k+1, for exactly one cycle.
- Back-to-back actions are separated by COOLDOWN+1 edges (1 edge when COOLDOWN=0).
- A tick is applied at the first IDLE edge after tick_pending sets; `tick` is high for one cycle.
- `busy` is registered state decode: high from the edge entering COOL through the last COOL cycle.
- Outputs are all registered; there are no combinational input-to-output paths.

## Test plan
- Reset, then hold `action_req`=0 with TICK_COUNT=4: `tick` pulses every 4 cycles. After 1 tick, hunger=1, happiness=14, health=15. After 15 ticks, hunger=15, hygiene=0, and health decreases from tick 16.
- Pulse feed (bit 0) with hunger=10: `action_ack`=6'b000001 exactly one cycle later, hunger=6, health saturates at 15. Holding the button high for 50 cycles gives only one ack.
- Raise feed, play and heal on the same cycle with COOLDOWN=4: acks arrive in order bit0, bit1, bit5, 5 edges apart. `busy` is high between them.
- Round-robin: after bit1 is granted, pending={0,2} grants bit2 before bit0.
- Tick and action pending together in IDLE: decay is applied first (`tick`=1), then the action on the next edge. With TICK_COUNT=2 and COOLDOWN=8, `tick_overrun` goes high and stays high.
- Assert `reset` during COOL with pending≠0: on the next edge all stats return to reset values. There is no `action_ack` afterwards, and the FSM is IDLE.
